auction_round_ctrl: RTL and testbench
=====================================

// Module: auction_round_ctrl
// PURPOSE
//  Sequences one sealed-bid auction round over 10 bidders and drives the external 10-way argmax stage.
//  Collects at most one bid per bidder inside a timed window, then presents the frozen bid vector to the argmax.
//  Captures the registered winner index, applies a reserve price and returns the result over a valid/ready handshake.
//  Sits between the bidder agents and the argmax datapath; owns all round sequencing.
// PARAMETERS
//  bW      17   bid width in bits, matches the argmax bid width
//  WIN_CYC 64   collection-window length in cycles (>=1)
//  CW      7    window counter width, must satisfy 2**CW > WIN_CYC
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        synchronous active-low reset
//  start          in   1        pulse: open a new round (ignored unless IDLE)
//  reserve        in   bW       minimum sale price, sampled on accepted start
//  bid_valid      in   10       per-bidder bid strobe
//  bid_data       in   10x bW   per-bidder bid value
//  bid_ready      out  10       bidder i may submit (COLLECT and not yet accepted)
//  amax_bids      out  10x bW   bid vector to argmax
//  amax_win       in   4        registered winner index from argmax (1-cycle latency)
//  busy           out  1        high in every state except IDLE
//  res_valid      out  1        result available
//  res_ready      in   1        consumer accepts result
//  res_winner     out  4        winning bidder index 0..9
//  res_bid        out  bW       winning bid value
//  res_no_sale    out  1        winning bid < reserve (res_winner still reported)
//  round_cnt      out  16       completed rounds, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, bid store and accepted mask cleared; applies mid-round, aborts the round, no result.
//  FSM: IDLE -> COLLECT -> EVAL -> CAPT -> RESULT -> IDLE.
//  IDLE: start=1 latches reserve, clears bid store and mask, loads counter=WIN_CYC-1, goes to COLLECT next cycle.
//  COLLECT: bid accepted for i when bid_valid[i]&&bid_ready[i]; stores bid_data[i], sets mask[i], and drops bid_ready[i] next cycle.
//   Simultaneous bids from several bidders in one cycle are all accepted.
//   Exit when counter==0 or mask==all ones (early close); an acceptance in the exit cycle still counts.
//   Counter decrements once per COLLECT cycle. Bidders that never submit contribute bid 0.
//  EVAL: amax_bids = frozen store (held constant in EVAL and CAPT, and driven as store at all times). Duration is 1 cycle.
//  CAPT: samples amax_win, sets res_winner=amax_win and res_bid=store[amax_win].
//   Also sets res_no_sale=(res_bid<reserve), unsigned compare.
//   amax_win values greater than 9 are clamped to res_no_sale=1, res_bid=0.
//  RESULT: res_valid=1, result fields stable until res_valid&&res_ready.
//   On handshake: res_valid=0, round_cnt+1 (wrap), go to IDLE. A start pulse in RESULT is ignored.
//  Latency: close of COLLECT to res_valid = 2 cycles. bid_ready=0 outside COLLECT. start outside IDLE is ignored.
// TESTING
//  T1 reserve=100; bids 5,40,300,7,0,0,0,0,0,9 all in cycle 1 -> early close, res_winner=2, res_bid=300, no_sale=0, round_cnt=1.
//  T2 only bidder 9 bids 50, reserve=60 -> window expires after 64 cycles, res_winner=9, res_bid=50, res_no_sale=1.
//  T3 bidder 3 strobes 10 then 999 -> only 10 stored, bid_ready[3]=0 after first; bidder 6 bids 20 -> winner=6.
//  T4 hold res_ready=0 for 20 cycles -> result stable and res_valid held; start pulses ignored, busy=1 throughout.
//  T5 rst_n=0 for 1 cycle mid-COLLECT -> next cycle IDLE, all outputs 0, round_cnt unchanged from reset value 0.
//  T6 run 0xFFFF rounds (or force counter) then one more round -> round_cnt wraps to 0.

Source files
------------

// File: rtl/auction_round_ctrl.sv
// Sealed-bid round sequencer for 10 bidders: timed bid collection, argmax hand-off,
// reserve check and valid/ready result return.
module auction_round_ctrl #(
  parameter int unsigned bW      = 17,
  parameter int unsigned WIN_CYC = 64,
  parameter int unsigned CW      = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [bW-1:0]    reserve,
  input  logic [9:0]       bid_valid,
  input  logic [10*bW-1:0] bid_data,
  output logic [9:0]       bid_ready,
  output logic [10*bW-1:0] amax_bids,
  input  logic [3:0]       amax_win,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_winner,
  output logic [bW-1:0]    res_bid,
  output logic             res_no_sale,
  output logic [15:0]      round_cnt
);

  localparam int unsigned NB = 10;

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_EVAL, S_CAPT, S_RESULT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [bW-1:0]   reserve_q, reserve_d;
  logic [bW-1:0]   store_q [NB];
  logic [bW-1:0]   store_d [NB];
  logic [NB-1:0]   mask_q, mask_d;
  logic [NB-1:0]   bid_ready_q, bid_ready_d;
  logic            busy_q, busy_d;
  logic            res_valid_q, res_valid_d;
  logic [3:0]      res_winner_q, res_winner_d;
  logic [bW-1:0]   res_bid_q, res_bid_d;
  logic            res_no_sale_q, res_no_sale_d;
  logic [15:0]     round_cnt_q, round_cnt_d;
  logic [NB-1:0]   accept_c;
  logic [bW-1:0]   win_bid_c;

  // Store is always visible to the argmax; it only changes during COLLECT.
  for (genvar g = 0; g < NB; g++) begin : g_amax
    assign amax_bids[g*bW +: bW] = store_q[g];
  end

  // Bid lookup for the argmax winner; indices above 9 select nothing.
  always_comb begin
    win_bid_c = '0;
    for (int i = 0; i < NB; i++) begin
      if (amax_win == 4'(i)) win_bid_c = store_q[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    reserve_d     = reserve_q;
    store_d       = store_q;
    mask_d        = mask_q;
    bid_ready_d   = bid_ready_q;
    busy_d        = busy_q;
    res_valid_d   = res_valid_q;
    res_winner_d  = res_winner_q;
    res_bid_d     = res_bid_q;
    res_no_sale_d = res_no_sale_q;
    round_cnt_d   = round_cnt_q;
    accept_c      = (state_q == S_COLLECT) ? (bid_valid & bid_ready_q) : '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          reserve_d   = reserve;
          for (int i = 0; i < NB; i++) store_d[i] = '0;
          mask_d      = '0;
          cnt_d       = CW'(WIN_CYC - 1);
          bid_ready_d = '1;
          busy_d      = 1'b1;
          state_d     = S_COLLECT;
        end
      end
      S_COLLECT: begin
        for (int i = 0; i < NB; i++) begin
          if (accept_c[i]) store_d[i] = bid_data[i*bW +: bW];
        end
        mask_d = mask_q | accept_c;
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        // Early close counts acceptances made in this same cycle.
        if (cnt_q == '0 || &mask_d) begin
          bid_ready_d = '0;
          state_d     = S_EVAL;
        end else begin
          bid_ready_d = ~mask_d;
        end
      end
      S_EVAL: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        res_winner_d = amax_win;
        if (amax_win > 4'd9) begin
          res_bid_d     = '0;
          res_no_sale_d = 1'b1;
        end else begin
          res_bid_d     = win_bid_c;
          res_no_sale_d = (win_bid_c < reserve_q);
        end
        res_valid_d = 1'b1;
        state_d     = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          round_cnt_d = round_cnt_q + 16'd1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      reserve_q     <= '0;
      for (int i = 0; i < NB; i++) store_q[i] <= '0;
      mask_q        <= '0;
      bid_ready_q   <= '0;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_winner_q  <= '0;
      res_bid_q     <= '0;
      res_no_sale_q <= 1'b0;
      round_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      reserve_q     <= reserve_d;
      for (int i = 0; i < NB; i++) store_q[i] <= store_d[i];
      mask_q        <= mask_d;
      bid_ready_q   <= bid_ready_d;
      busy_q        <= busy_d;
      res_valid_q   <= res_valid_d;
      res_winner_q  <= res_winner_d;
      res_bid_q     <= res_bid_d;
      res_no_sale_q <= res_no_sale_d;
      round_cnt_q   <= round_cnt_d;
    end
  end

  assign bid_ready   = bid_ready_q;
  assign busy        = busy_q;
  assign res_valid   = res_valid_q;
  assign res_winner  = res_winner_q;
  assign res_bid     = res_bid_q;
  assign res_no_sale = res_no_sale_q;
  assign round_cnt   = round_cnt_q;

endmodule

// File: tb/tb_auction_round_ctrl.sv
// Directed bench for auction_round_ctrl with a registered argmax model in the loop.
module tb_auction_round_ctrl;

  localparam int unsigned BW = 17;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [BW-1:0]   reserve;
  logic [9:0]      bid_valid;
  logic [10*BW-1:0] bid_data;
  logic [9:0]      bid_ready;
  logic [10*BW-1:0] amax_bids;
  logic [3:0]      amax_win;
  logic            busy;
  logic            res_valid;
  logic            res_ready;
  logic [3:0]      res_winner;
  logic [BW-1:0]   res_bid;
  logic            res_no_sale;
  logic [15:0]     round_cnt;

  int errors = 0;
  int checks = 0;

  logic       force_win;
  logic [3:0] force_val;

  auction_round_ctrl #(.bW(BW), .WIN_CYC(64), .CW(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reserve(reserve),
    .bid_valid(bid_valid), .bid_data(bid_data), .bid_ready(bid_ready),
    .amax_bids(amax_bids), .amax_win(amax_win), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_winner(res_winner),
    .res_bid(res_bid), .res_no_sale(res_no_sale), .round_cnt(round_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External argmax stand-in: one-cycle registered, lowest index wins ties.
  function automatic logic [3:0] argmax(input logic [10*BW-1:0] v);
    logic [BW-1:0] best;
    logic [3:0]    idx;
    best = v[BW-1:0];
    idx  = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (v[i*BW +: BW] > best) begin
        best = v[i*BW +: BW];
        idx  = 4'(i);
      end
    end
    return idx;
  endfunction

  always @(posedge clk) amax_win <= force_win ? force_val : argmax(amax_bids);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_bid(input int i, input logic [BW-1:0] v);
    bid_data[i*BW +: BW] = v;
  endtask

  function automatic logic [BW-1:0] amax_at(input int i);
    return amax_bids[i*BW +: BW];
  endfunction

  task automatic open_round(input logic [BW-1:0] rsv);
    start   = 1'b1;
    reserve = rsv;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    reserve   = '0;
    bid_valid = '0;
    bid_data  = '0;
    res_ready = 1'b0;
    force_win = 1'b0;
    force_val = 4'd0;
    step();
    step();

    // Reset state
    chk("rst_busy",      32'(busy),        32'd0);
    chk("rst_res_valid", 32'(res_valid),   32'd0);
    chk("rst_bid_ready", 32'(bid_ready),   32'd0);
    chk("rst_round_cnt", 32'(round_cnt),   32'd0);
    chk("rst_res_bid",   32'(res_bid),     32'd0);
    chk("rst_winner",    32'(res_winner),  32'd0);
    chk("rst_no_sale",   32'(res_no_sale), 32'd0);
    rst_n = 1'b1;
    step();

    // T1: all ten bid in the first collect cycle -> early close, exact latency
    open_round(17'd100);
    chk("t1_bid_ready_open", 32'(bid_ready), 32'h3FF);
    chk("t1_busy_open",      32'(busy),      32'd1);
    set_bid(0, 5); set_bid(1, 40); set_bid(2, 300); set_bid(3, 7); set_bid(4, 0);
    set_bid(5, 0); set_bid(6, 0);  set_bid(7, 0);   set_bid(8, 0); set_bid(9, 9);
    bid_valid = 10'h3FF;
    step();
    bid_valid = '0;
    chk("t1_bid_ready_closed", 32'(bid_ready), 32'd0);
    chk("t1_amax2",            32'(amax_at(2)), 32'd300);
    chk("t1_amax0",            32'(amax_at(0)), 32'd5);
    chk("t1_valid_early",      32'(res_valid), 32'd0);
    step();
    chk("t1_valid_capt",       32'(res_valid), 32'd0);
    step();
    chk("t1_res_valid",        32'(res_valid),   32'd1);
    chk("t1_winner",           32'(res_winner),  32'd2);
    chk("t1_bid",              32'(res_bid),     32'd300);
    chk("t1_no_sale",          32'(res_no_sale), 32'd0);
    handshake();
    chk("t1_valid_after",      32'(res_valid), 32'd0);
    chk("t1_busy_after",       32'(busy),      32'd0);
    chk("t1_round_cnt",        32'(round_cnt), 32'd1);

    // T2: single bidder, window runs the full 64 cycles
    open_round(17'd60);
    set_bid(9, 50);
    bid_valid = 10'h200;
    step();
    bid_valid = '0;
    chk("t2_bid_ready_after", 32'(bid_ready), 32'h1FF);
    chk("t2_store_cleared",   32'(amax_at(0)), 32'd0);
    for (int k = 0; k < 62; k++) step();
    chk("t2_last_collect_ready", 32'(bid_ready), 32'h1FF);
    step();
    chk("t2_closed_ready",    32'(bid_ready), 32'd0);
    chk("t2_busy_eval",       32'(busy),      32'd1);
    step();
    chk("t2_valid_capt",      32'(res_valid), 32'd0);
    step();
    chk("t2_res_valid",       32'(res_valid),   32'd1);
    chk("t2_winner",          32'(res_winner),  32'd9);
    chk("t2_bid",             32'(res_bid),     32'd50);
    chk("t2_no_sale",         32'(res_no_sale), 32'd1);
    handshake();
    chk("t2_round_cnt",       32'(round_cnt), 32'd2);

    // T3: repeat bid from bidder 3 is not accepted
    open_round(17'd15);
    set_bid(3, 10);
    bid_valid = 10'h008;
    step();
    chk("t3_ready_drop3", 32'(bid_ready), 32'h3F7);
    set_bid(3, 999);
    set_bid(6, 20);
    bid_valid = 10'h048;
    step();
    bid_valid = '0;
    chk("t3_ready_drop6", 32'(bid_ready), 32'h3B7);
    chk("t3_store3",      32'(amax_at(3)), 32'd10);
    chk("t3_store6",      32'(amax_at(6)), 32'd20);
    wait_result("t3");
    chk("t3_winner",      32'(res_winner),  32'd6);
    chk("t3_bid",         32'(res_bid),     32'd20);
    chk("t3_no_sale",     32'(res_no_sale), 32'd0);

    // T4: consumer stalls 20 cycles while start is pulsed
    for (int k = 0; k < 20; k++) begin
      start = (k % 2 == 0);
      step();
      chk("t4_valid",  32'(res_valid),  32'd1);
      chk("t4_winner", 32'(res_winner), 32'd6);
      chk("t4_bid",    32'(res_bid),    32'd20);
      chk("t4_busy",   32'(busy),       32'd1);
    end
    start = 1'b0;
    chk("t4_round_cnt_held", 32'(round_cnt), 32'd2);
    handshake();
    chk("t4_round_cnt", 32'(round_cnt), 32'd3);
    chk("t4_busy_idle", 32'(busy),      32'd0);
    step();
    chk("t4_stays_idle", 32'(busy), 32'd0);

    // Bid equal to reserve is a sale
    open_round(17'd50);
    for (int i = 0; i < 10; i++) set_bid(i, 17'(i));
    set_bid(1, 50);
    bid_valid = 10'h3FF;
    step();
    bid_valid = '0;
    wait_result("eq");
    chk("eq_winner",  32'(res_winner),  32'd1);
    chk("eq_bid",     32'(res_bid),     32'd50);
    chk("eq_no_sale", 32'(res_no_sale), 32'd0);
    handshake();
    chk("eq_round_cnt", 32'(round_cnt), 32'd4);

    // Out-of-range argmax index
    force_win = 1'b1;
    force_val = 4'd12;
    open_round(17'd0);
    for (int i = 0; i < 10; i++) set_bid(i, 17'd1000);
    bid_valid = 10'h3FF;
    step();
    bid_valid = '0;
    wait_result("clamp");
    chk("clamp_bid",     32'(res_bid),     32'd0);
    chk("clamp_no_sale", 32'(res_no_sale), 32'd1);
    handshake();
    force_win = 1'b0;
    chk("clamp_round_cnt", 32'(round_cnt), 32'd5);

    // T5: reset mid-collect aborts the round
    open_round(17'd5);
    set_bid(2, 77);
    bid_valid = 10'h004;
    step();
    bid_valid = '0;
    chk("t5_store2", 32'(amax_at(2)), 32'd77);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_busy",      32'(busy),        32'd0);
    chk("t5_bid_ready", 32'(bid_ready),   32'd0);
    chk("t5_res_valid", 32'(res_valid),   32'd0);
    chk("t5_round_cnt", 32'(round_cnt),   32'd0);
    chk("t5_amax",      32'(amax_at(2)),  32'd0);
    chk("t5_res_bid",   32'(res_bid),     32'd0);
    chk("t5_winner",    32'(res_winner),  32'd0);
    chk("t5_no_sale",   32'(res_no_sale), 32'd0);
    for (int k = 0; k < 5; k++) step();
    chk("t5_no_result", 32'(res_valid), 32'd0);
    chk("t5_idle",      32'(busy),      32'd0);

    // T6: round counter wraps
    force dut.round_cnt_q = 16'hFFFF;
    step();
    release dut.round_cnt_q;
    step();
    chk("t6_preset", 32'(round_cnt), 32'hFFFF);
    open_round(17'd0);
    for (int i = 0; i < 10; i++) set_bid(i, 17'(i + 1));
    bid_valid = 10'h3FF;
    step();
    bid_valid = '0;
    wait_result("t6");
    chk("t6_winner", 32'(res_winner), 32'd9);
    chk("t6_bid",    32'(res_bid),    32'd10);
    handshake();
    chk("t6_wrap",   32'(round_cnt),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
